// File: rtl/simon_key_schedule_if.sv
// ---------------------------------------------------------------------------
// simon_key_schedule_if
// Handshake bundle between the key-schedule block, its key source and the
// round-key consumer.
//   key_in    N*M  master key, word j in key_in[j*N +: N]
//   key_valid 1    master key offered
//   key_ready 1    schedule idle and able to take a key
//   rk        N    current round key
//   rk_valid  1    rk holds a valid round key
//   rk_ready  1    consumer takes rk this cycle
//   rk_index  6    round number of rk
//   rk_last   1    rk is the final round key of the run
// Modports: slave = key-schedule block, master = the environment driving it.
// ---------------------------------------------------------------------------
interface simon_key_schedule_if #(
    parameter int N = 16,
    parameter int M = 4
);
    logic [N*M-1:0] key_in;
    logic           key_valid;
    logic           key_ready;
    logic [N-1:0]   rk;
    logic           rk_valid;
    logic           rk_ready;
    logic [5:0]     rk_index;
    logic           rk_last;

    modport slave (
        input  key_in, key_valid, rk_ready,
        output key_ready, rk, rk_valid, rk_index, rk_last
    );

    modport master (
        output key_in, key_valid, rk_ready,
        input  key_ready, rk, rk_valid, rk_index, rk_last
    );
endinterface

// File: rtl/simon_key_schedule.sv
// ---------------------------------------------------------------------------
// simon_key_schedule
// Iterative Simon key expansion. Accepts one M-word master key and emits
// round keys k[0]..k[ROUNDS-1] in order, one word per rk handshake.
// Defaults give Simon32/64 (N=16, M=4, 32 rounds, sequence z0).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    simon_key_schedule_if.slave (key load + round-key stream)
// ---------------------------------------------------------------------------
module simon_key_schedule #(
    parameter int          N      = 16,
    parameter int          M      = 4,
    parameter int          ROUNDS = 32,
    parameter logic [61:0] Z      = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic                 clk,
    input  logic                 reset,
    simon_key_schedule_if.slave  bus
);

    localparam logic [5:0] LAST_RC = 6'(ROUNDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   w_q [M];
    logic [N-1:0]   w_d [M];
    logic [5:0]     rc_q, rc_d;
    logic [5:0]     zi_q, zi_d;
    logic           key_ready_q, key_ready_d;
    logic           rk_valid_q, rk_valid_d;
    logic           rk_last_q, rk_last_d;

    logic [N-1:0]   t_ror3;
    logic [N-1:0]   t_mix;
    logic [N-1:0]   t_full;
    logic           z_bit;
    logic [N-1:0]   new_word;

    // Next key word from the current window. Z is stored MSB-first, so
    // z[zi] lives at bit 61-zi.
    always_comb begin
        t_ror3   = {w_q[M-1][2:0], w_q[M-1][N-1:3]};
        t_mix    = (M == 4) ? (t_ror3 ^ w_q[1]) : t_ror3;
        t_full   = t_mix ^ {t_mix[0], t_mix[N-1:1]};
        z_bit    = Z[6'd61 - zi_q];
        new_word = ~w_q[0] ^ t_full ^ {{(N-1){1'b0}}, z_bit} ^ N'(3);
    end

    // Next-state logic. Outputs are derived from the next state so that
    // they leave the block straight from flops.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        rc_d    = rc_q;
        zi_d    = zi_q;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    state_d = RUN;
                    for (int j = 0; j < M; j++) begin
                        w_d[j] = bus.key_in[j*N +: N];
                    end
                    rc_d = 6'd0;
                    zi_d = 6'd0;
                end
            end
            RUN: begin
                if (bus.rk_ready) begin
                    if (rc_q == LAST_RC) begin
                        state_d = IDLE;
                    end else begin
                        for (int j = 0; j < M-1; j++) begin
                            w_d[j] = w_q[j+1];
                        end
                        w_d[M-1] = new_word;
                        rc_d     = rc_q + 6'd1;
                        zi_d     = (zi_q == 6'd61) ? 6'd0 : zi_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        key_ready_d = (state_d == IDLE);
        rk_valid_d  = (state_d == RUN);
        rk_last_d   = (state_d == RUN) && (rc_d == LAST_RC);
    end

    // State, window and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rc_q        <= 6'd0;
            zi_q        <= 6'd0;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
            for (int j = 0; j < M; j++) begin
                w_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            zi_q        <= zi_d;
            key_ready_q <= key_ready_d;
            rk_valid_q  <= rk_valid_d;
            rk_last_q   <= rk_last_d;
            for (int j = 0; j < M; j++) begin
                w_q[j] <= w_d[j];
            end
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rk_last   = rk_last_q;
    assign bus.rk        = w_q[0];
    assign bus.rk_index  = rc_q;

endmodule

// File: tb/tb_simon_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_simon_key_schedule
// Directed bench for simon_key_schedule (Simon32/64 defaults). Inputs are
// driven and outputs sampled on the falling edge; a handshake therefore
// happens at the rising edge following a sample with rk_valid & rk_ready.
// ---------------------------------------------------------------------------
module tb_simon_key_schedule;

    localparam logic [63:0] KEY_A = 64'h1918111009080100;
    localparam logic [63:0] KEY_B = 64'h0123456789abcdef;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    simon_key_schedule_if #(.N(16), .M(4)) bus ();

    simon_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checkCount = 0;
    int          passCount  = 0;
    logic [15:0] modelKeys [32];
    logic [15:0] gotKeys   [32];
    logic [61:0] zSeq;

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    // Drives every input of the block in one step.
    task automatic applyStimulus(input logic kv, input logic [63:0] k, input logic rr);
        bus.key_valid = kv;
        bus.key_in    = k;
        bus.rk_ready  = rr;
    endtask

    function automatic logic [15:0] ror16(input logic [15:0] x, input int s);
        return (x >> s) | (x << (16 - s));
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] x, input int s);
        return (x << s) | (x >> (16 - s));
    endfunction

    // Reference Simon32/64 key expansion written from the cipher definition.
    task automatic buildModel(input logic [63:0] key);
        logic [15:0] k [32];
        logic [15:0] tmp;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 0; i < 28; i++) begin
            tmp = ror16(k[i+3], 3) ^ k[i+1];
            tmp = tmp ^ ror16(tmp, 1);
            k[i+4] = ~k[i] ^ tmp ^ {15'b0, zSeq[61 - (i % 62)]} ^ 16'h0003;
        end
        for (int i = 0; i < 32; i++) modelKeys[i] = k[i];
    endtask

    // Offers a key for one cycle while the block is idle.
    task automatic loadKey(input logic [63:0] key);
        checkOutput("key_ready_before_load", bus.key_ready, 1);
        applyStimulus(1'b1, key, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, key, 1'b1);
        checkOutput("rk_valid_after_load", bus.rk_valid, 1);
    endtask

    // Consumes round keys 0..stopAt-1 and compares them to the model.
    task automatic drainKeys(input bit randomReady, input int injectAt,
                             input int stopAt, input bit holdValid);
        int          idx = 0;
        int          budget = 0;
        bit          held = 0;
        bit          injected = 0;
        logic [15:0] heldRk = '0;
        logic [5:0]  heldIdx = '0;
        logic        rr;
        logic        inject;
        while (idx < stopAt) begin
            if (budget++ > 400) begin
                checkOutput("drain_timeout", idx, stopAt);
                return;
            end
            if (held) begin
                checkOutput("rk_stable", bus.rk, heldRk);
                checkOutput("rk_index_stable", bus.rk_index, heldIdx);
            end
            if (bus.rk_valid !== 1'b1) begin
                checkOutput("rk_valid_in_run", bus.rk_valid, 1);
                return;
            end
            rr     = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            inject = (idx == injectAt) && !injected;
            if (inject) injected = 1;
            applyStimulus(holdValid | inject, inject ? 64'h0 : bus.key_in, rr);
            if (rr) begin
                gotKeys[idx] = bus.rk;
                checkOutput($sformatf("rk[%0d]", idx), bus.rk, modelKeys[idx]);
                checkOutput($sformatf("rk_index[%0d]", idx), bus.rk_index, idx);
                checkOutput($sformatf("rk_last[%0d]", idx), bus.rk_last, (idx == 31));
                idx++;
                held = 0;
            end else begin
                held    = 1;
                heldRk  = bus.rk;
                heldIdx = bus.rk_index;
            end
            @(negedge clk);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_key_ready"}, bus.key_ready, 1);
        checkOutput({tag, "_rk_valid"}, bus.rk_valid, 0);
        checkOutput({tag, "_rk_last"}, bus.rk_last, 0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] x, y, tmp;
        zSeq  = 62'b11111010001001010110000111001101111101000100101011000011100110;
        reset = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("reset_key_ready", bus.key_ready, 1);
        checkOutput("reset_rk_valid", bus.rk_valid, 0);
        checkOutput("reset_rk", bus.rk, 0);
        checkOutput("reset_rk_index", bus.rk_index, 0);
        checkOutput("reset_rk_last", bus.rk_last, 0);
        reset = 1'b0;
        @(negedge clk);

        // Full run with rk_ready held high
        $display("[TB] run A, rk_ready high");
        buildModel(KEY_A);
        loadKey(KEY_A);
        drainKeys(1'b0, -1, 32, 1'b0);
        checkIdle("after_run_a");
        checkOutput("hand_k0", gotKeys[0], 16'h0100);
        checkOutput("hand_k1", gotKeys[1], 16'h0908);
        checkOutput("hand_k2", gotKeys[2], 16'h1110);
        checkOutput("hand_k3", gotKeys[3], 16'h1918);
        checkOutput("hand_k4", gotKeys[4], 16'h71c3);

        // Encrypt the Simon32/64 test vector with the emitted keys
        x = 16'h6565;
        y = 16'h6877;
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ gotKeys[i];
            y   = tmp;
        end
        checkOutput("ciphertext", {x, y}, 32'hc69be9bb);

        // Random backpressure plus a stray key offer at index 5
        $display("[TB] run A, random rk_ready, key_valid pulse at index 5");
        loadKey(KEY_A);
        drainKeys(1'b1, 5, 32, 1'b0);
        checkIdle("after_random_run");
        repeat (3) @(negedge clk);
        checkOutput("no_second_run", bus.rk_valid, 0);

        // Reset in the middle of a run with a key offered
        $display("[TB] reset at index 10");
        applyStimulus(1'b0, KEY_A, 1'b1);
        loadKey(KEY_A);
        drainKeys(1'b0, -1, 10, 1'b0);
        checkOutput("pre_reset_index", bus.rk_index, 10);
        reset = 1'b1;
        applyStimulus(1'b1, KEY_A, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, KEY_A, 1'b1);
        checkOutput("mid_reset_rk_valid", bus.rk_valid, 0);
        checkOutput("mid_reset_key_ready", bus.key_ready, 1);
        checkOutput("mid_reset_rk", bus.rk, 0);
        checkOutput("mid_reset_rk_index", bus.rk_index, 0);
        loadKey(KEY_A);
        drainKeys(1'b0, -1, 32, 1'b0);
        checkIdle("after_restart");

        // Back-to-back keys A then B with key_valid held
        $display("[TB] back-to-back keys");
        checkOutput("b2b_key_ready", bus.key_ready, 1);
        applyStimulus(1'b1, KEY_A, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, KEY_B, 1'b1);
        drainKeys(1'b0, -1, 32, 1'b1);
        checkIdle("b2b_gap");
        buildModel(KEY_B);
        @(negedge clk);
        applyStimulus(1'b0, KEY_B, 1'b1);
        checkOutput("b2b_rk_valid", bus.rk_valid, 1);
        checkOutput("b2b_rk_index", bus.rk_index, 0);
        checkOutput("b2b_rk", bus.rk, 16'hcdef);
        drainKeys(1'b0, -1, 32, 1'b0);
        checkOutput("b2b_k4", gotKeys[4], modelKeys[4]);
        checkIdle("after_run_b");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/simon_key_schedule.md
# simon_key_schedule

Iterative Simon key-expansion stage that sits directly upstream of the Simon round datapath. It accepts one M-word master key and emits the ROUNDS round keys k[0]..k[ROUNDS-1] in order, one word per accepted handshake. The encryption controller consumes these words as the per-round `k` input of the round function. Defaults implement Simon32/64: N=16, M=4, 32 rounds, sequence z0.

## Interface
- N, 16, word width in bits; must be ≥ 8.
- M, 4, key words; supported values are 2, 3 and 4.
- ROUNDS, 32, number of round keys emitted per master key.
- Z, 62'b11111010001001010110000111001101111101000100101011000011100110, constant sequence; Z[61] (leftmost) is z[0].
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- key_in  in  N*M  master key; key_in[N-1:0]=k[0], key_in[N*M-1 -: N]=k[M-1].
- key_valid  in  1  master key offered.
- key_ready  out  1  block idle and accepting a key.
- rk  out  N  current round key.
- rk_valid  out  1  rk holds a valid round key.
- rk_ready  in  1  consumer takes rk this cycle.
- rk_index  out  6  round number of rk, 0..ROUNDS-1.
- rk_last  out  1  rk is k[ROUNDS-1].

## Operation
- State machine has two states, IDLE and RUN.
  - key_ready = (state==IDLE).
  - rk_valid = (state==RUN).
- Storage:
  - Window register w[0..M-1] of N-bit words; rk = w[0].
  - Round counter rc (6 b), which drives rk_index.
  - z index zi (6 b).
- IDLE → RUN when key_valid & key_ready:
  - w[j] ← key_in word j.
  - rc ← 0, zi ← 0.
- In RUN, each handshake (rk_valid & rk_ready) does the following:
  - If rc == ROUNDS-1: state ← IDLE. w, rc and zi are don't-care.
  - Otherwise:
    - Shift: w[j] ← w[j+1] for j < M-1.
    - w[M-1] ← new.
    - rc ← rc+1.
    - zi ← (zi==61) ? 0 : zi+1.
- New word computation (all rotates N-bit; ROR = rotate right):
  - t = ROR(w[M-1],3).
  - If M==4: t ^= w[1].
  - t ^= ROR(t,1).
  - new = ~w[0] ^ t ^ {{N-1{0}}, z[zi]} ^ 3.
  - zi always equals (rc) mod 62 while rc indexes w[0]. The first generated word is k[M], which uses z[0].
- Without a handshake in RUN, all state holds. rk, rk_index and rk_last stay stable; there is no drop of rk_valid.
- rk_last = (state==RUN) & (rc==ROUNDS-1).
- key_valid during RUN is ignored. The key is not latched and the current run continues.
- There is no bypass: a new key can only be accepted on the cycle after the last handshake (key_ready high).

## Timing
- Reset values: state=IDLE, key_ready=1, rk_valid=0, rk=0, rk_index=0, rk_last=0. rc, zi and w are all zero.
- Reset has priority over every handshake in the same cycle. An assertion mid-run abandons the run; the next cycle shows IDLE.
- Key accepted at edge E: rk_valid=1 and rk=k[0] from E until the first handshake.
- Throughput is one round key per cycle while rk_ready is held high.
- A full run takes ROUNDS cycles from key acceptance, with rk_ready tied high.
- Next-word logic is one rotate/XOR level, registered; rk comes straight from a register with no combinational path from inputs.
- The last handshake drops rk_valid and raises key_ready on the next cycle. The earliest next key is accepted one cycle after the last handshake.
- rc never exceeds ROUNDS-1. zi wraps at 61→0, which matters for ROUNDS > 62+M-M.

## Test plan
- Reset, then load key_in=64'h1918111009080100 with rk_ready=1:
  - rk sequence starts 0100, 0908, 1110, 1918, 71C3.
  - rk_index runs 0..31.
  - rk_last is high only at index 31.
  - key_ready rises the cycle after.
- Same key, rk_ready toggled pseudo-randomly:
  - Identical 32-word sequence.
  - rk and rk_index stable whenever rk_valid & !rk_ready.
- Full Simon32/64 encryption of 6565_6877 using the emitted keys → ciphertext c69b_e9bb.
- key_valid pulsed with key_in=0 during RUN (index 5) → sequence unchanged and no second run.
- Reset asserted at rk_index 10 while key_valid=1 → next cycle rk_valid=0, key_ready=1, rk=0. A following key load restarts at k[0].
- Back-to-back keys A then B with key_valid held high:
  - B is accepted the cycle after A's k[31] handshake.
  - B's k[0] appears with rk_index=0.
  - zi restarts: B's k[4] matches its reference model.
